// File: rtl/add3_rr_if.sv
// Request/response bundle between N_REQ clients and the shared three-operand adder.
// Operands are packed per requester: requester i occupies bits [i*W +: W].
interface add3_rr_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  localparam int SUM_W = W + 2;

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ*W-1:0] req_c;
  logic [N_REQ-1:0]   req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [SUM_W-1:0]   rsp_sum;
  logic               rsp_parity;
  logic [15:0]        op_count;

  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_parity, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_parity, op_count
  );
endinterface

// File: rtl/add3_rr_scheduler.sv
// Round-robin scheduler that shares one registered a+b+c adder among N_REQ requesters.
// One operation in flight: IDLE (grant) -> CALC (add) -> RESP (hold until accepted).
module add3_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic     clock,
  input  logic     rst_n,
  add3_rr_if.slave bus
);
  localparam int SUM_W = W + 2;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_rsp_id;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_c;
  logic [SUM_W-1:0] r_sum;
  logic [15:0]      r_op_count;

  logic             w_grant_found;
  logic [ID_W-1:0]  w_grant_idx;
  logic [ID_W-1:0]  w_scan_idx;
  logic [ID_W-1:0]  w_rr_nxt;
  logic             w_grant_fire;
  logic             w_rsp_fire;

  // Circular priority search starting at r_rr_ptr; the first valid hit wins.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_scan_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan_idx = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_grant_found && bus.req_valid[w_scan_idx]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_scan_idx;
      end
    end
  end

  assign w_rr_nxt     = (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
  assign w_grant_fire = (r_state == S_IDLE) && w_grant_found;
  assign w_rsp_fire   = (r_state == S_RESP) && bus.rsp_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant_found) w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant is combinational and suppressed while reset is asserted.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = (r_state == S_RESP);
    if (rst_n && w_grant_fire) bus.req_ready[w_grant_idx] = 1'b1;
  end

  // NOTE: operand registers are always written on a grant before CALC reads them, so they need no reset.
  always_ff @(posedge clock) begin
    if (w_grant_fire) begin
      r_a <= bus.req_a[w_grant_idx*W +: W];
      r_b <= bus.req_b[w_grant_idx*W +: W];
      r_c <= bus.req_c[w_grant_idx*W +: W];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_rsp_id   <= '0;
      r_sum      <= '0;
      r_op_count <= '0;
    end else begin
      if (w_grant_fire) begin
        r_id     <= w_grant_idx;
        r_rr_ptr <= w_rr_nxt;
      end
      // Operands are widened before adding so the carry out of each stage is kept.
      if (r_state == S_CALC) begin
        r_sum    <= SUM_W'(r_a) + SUM_W'(r_b) + SUM_W'(r_c);
        r_rsp_id <= r_id;
      end
      if (w_rsp_fire) r_op_count <= r_op_count + 16'd1;
    end
  end

  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_sum    = r_sum;
  assign bus.rsp_parity = ^~r_sum;
  assign bus.op_count   = r_op_count;
endmodule
